// File: rtl/instr_encoder_loader.sv
// Encodes symbolic MIPS instruction requests into 32-bit words and writes them
// sequentially into instruction memory through an acknowledged write port.
module instr_encoder_loader #(
  parameter int unsigned ADDR_W    = 6,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [15:0]       in_imm,
  input  logic              in_last,
  input  logic              restart,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  output logic [ADDR_W:0]   word_count,
  output logic              done,
  output logic              full,
  output logic              err
);

  typedef enum logic [1:0] {S_LOAD, S_WRITE, S_DONE} state_t;

  localparam logic [ADDR_W-1:0] BASE = BASE_ADDR[ADDR_W-1:0];
  localparam logic [ADDR_W:0]   CAP  = {1'b1, {ADDR_W{1'b0}}};

  state_t          state;
  logic            last_q;
  logic            legal;
  logic [31:0]     enc;
  logic [ADDR_W:0] wc_next;

  always_comb begin
    legal = 1'b1;
    enc   = '0;
    unique case (in_op)
      4'd0: enc = {6'b000000, in_rs, in_rt, in_rd, 5'b0, 6'b100000};
      4'd1: enc = {6'b000000, in_rs, in_rt, in_rd, 5'b0, 6'b100010};
      4'd2: enc = {6'b000000, in_rs, in_rt, in_rd, 5'b0, 6'b100100};
      4'd3: enc = {6'b000000, in_rs, in_rt, in_rd, 5'b0, 6'b100101};
      4'd4: enc = {6'b000000, in_rs, in_rt, in_rd, 5'b0, 6'b101010};
      4'd5: enc = {6'b100011, in_rs, in_rt, in_imm};
      4'd6: enc = {6'b101011, in_rs, in_rt, in_imm};
      4'd7: enc = {6'b000100, in_rs, in_rt, in_imm};
      4'd8: enc = {6'b001000, in_rs, in_rt, in_imm};
      default: legal = 1'b0;
    endcase
  end

  assign wc_next = word_count + (ADDR_W+1)'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_LOAD;
      in_ready   <= 1'b1;
      mem_we     <= 1'b0;
      mem_addr   <= BASE;
      mem_wdata  <= '0;
      word_count <= '0;
      done       <= 1'b0;
      full       <= 1'b0;
      err        <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      unique case (state)
        S_LOAD: begin
          if (in_valid) begin
            if (legal) begin
              mem_wdata <= enc;
              mem_we    <= 1'b1;
              in_ready  <= 1'b0;
              last_q    <= in_last;
              state     <= S_WRITE;
            end else begin
              err <= 1'b1;
              if (in_last) begin
                in_ready <= 1'b0;
                done     <= 1'b1;
                state    <= S_DONE;
              end
            end
          end
        end
        S_WRITE: begin
          if (mem_ack) begin
            mem_we     <= 1'b0;
            word_count <= wc_next;
            mem_addr   <= mem_addr + ADDR_W'(1);
            // Capacity reached ends the load even without in_last.
            if (last_q || wc_next == CAP) begin
              full  <= (wc_next == CAP);
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              in_ready <= 1'b1;
              state    <= S_LOAD;
            end
          end
        end
        S_DONE: begin
          if (restart) begin
            word_count <= '0;
            mem_addr   <= BASE;
            done       <= 1'b0;
            full       <= 1'b0;
            err        <= 1'b0;
            in_ready   <= 1'b1;
            state      <= S_LOAD;
          end
        end
        default: state <= S_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench: a default-size loader for encoding/handshake and a 4-word
// loader for the capacity-full corner.
module tb_instr_encoder_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [3:0]  op;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;
  logic        last;

  logic        a_valid, a_ready, a_restart, a_we, a_ack, a_done, a_full, a_err;
  logic [5:0]  a_addr;
  logic [6:0]  a_wc;
  logic [31:0] a_wdata;

  logic        b_valid, b_ready, b_restart, b_we, b_ack, b_done, b_full, b_err;
  logic [1:0]  b_addr;
  logic [2:0]  b_wc;
  logic [31:0] b_wdata;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  instr_encoder_loader #(.ADDR_W(6), .BASE_ADDR(0)) dut_a (
    .clk(clk), .reset(reset), .in_valid(a_valid), .in_ready(a_ready),
    .in_op(op), .in_rs(rs), .in_rt(rt), .in_rd(rd), .in_imm(imm),
    .in_last(last), .restart(a_restart), .mem_we(a_we), .mem_addr(a_addr),
    .mem_wdata(a_wdata), .mem_ack(a_ack), .word_count(a_wc),
    .done(a_done), .full(a_full), .err(a_err)
  );

  instr_encoder_loader #(.ADDR_W(2), .BASE_ADDR(0)) dut_b (
    .clk(clk), .reset(reset), .in_valid(b_valid), .in_ready(b_ready),
    .in_op(op), .in_rs(rs), .in_rt(rt), .in_rd(rd), .in_imm(imm),
    .in_last(last), .restart(b_restart), .mem_we(b_we), .mem_addr(b_addr),
    .mem_wdata(b_wdata), .mem_ack(b_ack), .word_count(b_wc),
    .done(b_done), .full(b_full), .err(b_err)
  );

  typedef struct {
    logic [3:0]  op;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic        last;
    logic [31:0] exp_word;
  } vec_t;

  vec_t prog [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_fields(input logic [3:0] o, input logic [4:0] s, input logic [4:0] t,
                            input logic [4:0] d, input logic [15:0] i, input logic l);
    op = o; rs = s; rt = t; rd = d; imm = i; last = l;
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_a(input logic [3:0] o, input logic [4:0] s, input logic [4:0] t,
                        input logic [4:0] d, input logic [15:0] i, input logic l);
    for (int k = 0; k < 20 && !a_ready; k++) @(negedge clk);
    chk("a_ready_before_send", {31'b0, a_ready}, 32'd1);
    set_fields(o, s, t, d, i, l);
    a_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a_valid = 1'b0;
  endtask

  task automatic ack_a(input int unsigned delay, input logic [31:0] exp_addr,
                       input logic [31:0] exp_word, input logic [31:0] exp_wc);
    chk("a_we_after_accept", {31'b0, a_we}, 32'd1);
    chk("a_addr", {26'b0, a_addr}, exp_addr);
    chk("a_wdata", a_wdata, exp_word);
    chk("a_ready_in_write", {31'b0, a_ready}, 32'd0);
    for (int unsigned k = 0; k < delay; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("a_we_hold", {31'b0, a_we}, 32'd1);
      chk("a_addr_hold", {26'b0, a_addr}, exp_addr);
      chk("a_wdata_hold", a_wdata, exp_word);
      chk("a_ready_hold", {31'b0, a_ready}, 32'd0);
      chk("a_wc_hold", {25'b0, a_wc}, exp_wc);
    end
    a_ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a_ack = 1'b0;
    chk("a_we_drop", {31'b0, a_we}, 32'd0);
    chk("a_wc_incr", {25'b0, a_wc}, exp_wc + 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    prog[0] = '{4'd5, 5'd29, 5'd8, 5'd0,  16'h0004, 1'b0, 32'h8FA80004};
    prog[1] = '{4'd6, 5'd29, 5'd8, 5'd0,  16'h0008, 1'b0, 32'hAFA80008};
    prog[2] = '{4'd7, 5'd1,  5'd2, 5'd0,  16'hFFFF, 1'b0, 32'h1022FFFF};
    prog[3] = '{4'd8, 5'd0,  5'd5, 5'd0,  16'h0007, 1'b0, 32'h20050007};
    prog[4] = '{4'd4, 5'd4,  5'd5, 5'd10, 16'h0000, 1'b1, 32'h0085502A};

    reset = 1'b1; a_valid = 1'b0; b_valid = 1'b0; a_ack = 1'b0; b_ack = 1'b0;
    a_restart = 1'b0; b_restart = 1'b0;
    set_fields(4'd0, 5'd0, 5'd0, 5'd0, 16'h0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    chk("rst_ready", {31'b0, a_ready}, 32'd1);
    chk("rst_we", {31'b0, a_we}, 32'd0);
    chk("rst_addr", {26'b0, a_addr}, 32'd0);
    chk("rst_wdata", a_wdata, 32'd0);
    chk("rst_wc", {25'b0, a_wc}, 32'd0);
    chk("rst_flags", {29'b0, a_done, a_full, a_err}, 32'd0);

    // Single add, acked on the first WRITE cycle.
    send_a(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 1'b0);
    ack_a(0, 32'd0, 32'h00221820, 32'd0);
    chk("add_back_in_load", {31'b0, a_ready}, 32'd1);

    // Idle LOAD with in_valid low: nothing moves.
    repeat (3) @(negedge clk);
    chk("idle_we", {31'b0, a_we}, 32'd0);
    chk("idle_wc", {25'b0, a_wc}, 32'd1);
    chk("idle_ready", {31'b0, a_ready}, 32'd1);

    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      send_a(prog[i].op, prog[i].rs, prog[i].rt, prog[i].rd, prog[i].imm, prog[i].last);
      ack_a(0, i, prog[i].exp_word, i);
    end
    chk("prog_done", {31'b0, a_done}, 32'd1);
    chk("prog_wc", {25'b0, a_wc}, 32'd5);
    chk("prog_ready", {31'b0, a_ready}, 32'd0);
    chk("prog_full", {31'b0, a_full}, 32'd0);

    // Request while done must not be consumed.
    set_fields(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 1'b0);
    a_valid = 1'b1;
    repeat (2) @(negedge clk);
    chk("done_stall_we", {31'b0, a_we}, 32'd0);
    chk("done_stall_wc", {25'b0, a_wc}, 32'd5);
    a_valid = 1'b0;

    a_restart = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a_restart = 1'b0;
    chk("restart_wc", {25'b0, a_wc}, 32'd0);
    chk("restart_addr", {26'b0, a_addr}, 32'd0);
    chk("restart_done", {31'b0, a_done}, 32'd0);
    chk("restart_ready", {31'b0, a_ready}, 32'd1);

    // Illegal op: handshake completes, no write, sticky error.
    send_a(4'd12, 5'd1, 5'd2, 5'd3, 16'h0, 1'b0);
    chk("illegal_err", {31'b0, a_err}, 32'd1);
    chk("illegal_no_we", {31'b0, a_we}, 32'd0);
    chk("illegal_wc", {25'b0, a_wc}, 32'd0);
    chk("illegal_ready", {31'b0, a_ready}, 32'd1);

    // Add with ack held off for three WRITE cycles.
    send_a(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 1'b0);
    ack_a(3, 32'd0, 32'h00221820, 32'd0);
    chk("err_sticky", {31'b0, a_err}, 32'd1);

    a_restart = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a_restart = 1'b0;
    chk("restart_in_load_ignored", {25'b0, a_wc}, 32'd1);

    // Reset while WRITE is waiting for ack.
    send_a(4'd1, 5'd1, 5'd2, 5'd3, 16'h0, 1'b0);
    chk("pre_reset_we", {31'b0, a_we}, 32'd1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("midwrite_rst_we", {31'b0, a_we}, 32'd0);
    chk("midwrite_rst_wc", {25'b0, a_wc}, 32'd0);
    chk("midwrite_rst_addr", {26'b0, a_addr}, 32'd0);
    chk("midwrite_rst_ready", {31'b0, a_ready}, 32'd1);
    chk("midwrite_rst_err", {31'b0, a_err}, 32'd0);

    // Capacity: 4-word memory fills without in_last.
    set_fields(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 20 && !b_ready; k++) @(negedge clk);
      chk("b_ready_before_send", {31'b0, b_ready}, 32'd1);
      b_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      b_valid = 1'b0;
      chk("b_we", {31'b0, b_we}, 32'd1);
      chk("b_addr", {30'b0, b_addr}, i);
      b_ack = 1'b1;
      @(posedge clk);
      @(negedge clk);
      b_ack = 1'b0;
    end
    chk("b_full", {31'b0, b_full}, 32'd1);
    chk("b_done", {31'b0, b_done}, 32'd1);
    chk("b_ready_full", {31'b0, b_ready}, 32'd0);
    chk("b_wc_full", {29'b0, b_wc}, 32'd4);
    chk("b_addr_wrap", {30'b0, b_addr}, 32'd0);

    b_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("b_fifth_stalled_we", {31'b0, b_we}, 32'd0);
    chk("b_fifth_stalled_wc", {29'b0, b_wc}, 32'd4);
    chk("b_fifth_stalled_ready", {31'b0, b_ready}, 32'd0);

    b_restart = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b_restart = 1'b0;
    chk("b_restart_wc", {29'b0, b_wc}, 32'd0);
    chk("b_restart_addr", {30'b0, b_addr}, 32'd0);
    chk("b_restart_full", {31'b0, b_full}, 32'd0);
    chk("b_restart_ready", {31'b0, b_ready}, 32'd1);
    chk("b_restart_no_we", {31'b0, b_we}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    b_valid = 1'b0;
    chk("b_fifth_we", {31'b0, b_we}, 32'd1);
    chk("b_fifth_addr", {30'b0, b_addr}, 32'd0);
    chk("b_fifth_wdata", b_wdata, 32'h00221820);
    b_ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b_ack = 1'b0;
    chk("b_fifth_wc", {29'b0, b_wc}, 32'd1);
    chk("b_err_clear", {31'b0, b_err}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
